// File: rtl/dvfs_pkg.sv
// Shared types and the P-state operating-point table for the DVFS governor.
package dvfs_pkg;

   localparam int          NUM_PS    = 4;
   localparam logic [9:0]  MILLI_MAX = 10'd1000;

   typedef logic [1:0] pstate_t;

   typedef enum logic [2:0] {
      ST_ACCUM,
      ST_EVAL,
      ST_VUP,
      ST_FDN,
      ST_SETTLE
   } gov_state_t;

   // Handshake sub-phases inside VUP/FDN.
   typedef enum logic [1:0] {
      PH_ISSUE,
      PH_WAIT,
      PH_FREQ
   } hs_phase_t;

   function automatic logic [15:0] ps_freq_mhz(input pstate_t p);
      case (p)
         2'd0:    ps_freq_mhz = 16'd200;
         2'd1:    ps_freq_mhz = 16'd400;
         2'd2:    ps_freq_mhz = 16'd600;
         default: ps_freq_mhz = 16'd800;
      endcase
   endfunction

   function automatic logic [15:0] ps_volt_mv(input pstate_t p);
      case (p)
         2'd0:    ps_volt_mv = 16'd650;
         2'd1:    ps_volt_mv = 16'd700;
         2'd2:    ps_volt_mv = 16'd800;
         default: ps_volt_mv = 16'd900;
      endcase
   endfunction

endpackage

// File: rtl/dvfs_pstate_governor_if.sv
// Regulator request/acknowledge channel between the governor and the vreg.
interface dvfs_pstate_governor_if;
   logic        vreg_req;
   logic [15:0] vreg_target_mv;
   logic        vreg_ack;

   modport master (output vreg_req, output vreg_target_mv, input vreg_ack);
   modport slave  (input vreg_req, input vreg_target_mv, output vreg_ack);
endinterface

// File: rtl/util_window_avg.sv
// Clamps the utilization sample, accumulates it over a 2^WIN_LOG2 window and
// produces the window average together with a one-cycle done strobe.
module util_window_avg
   import dvfs_pkg::*;
#(
   parameter int WIN_LOG2 = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en_i,
   input  logic       clr_i,
   input  logic [9:0] util_i,
   output logic       done_o,
   output logic [9:0] avg_o
);
   localparam int AW = 10 + WIN_LOG2;

   logic [AW-1:0]       acc_q, acc_d, sum;
   logic [WIN_LOG2-1:0] cnt_q, cnt_d;
   logic [9:0]          u_clamped;

   // Final sample of a window is folded into the average in the same cycle.
   always_comb begin
      u_clamped = (util_i > MILLI_MAX) ? MILLI_MAX : util_i;
      sum       = acc_q + AW'(u_clamped);
      done_o    = en_i && (cnt_q == '1);
      avg_o     = sum[AW-1:WIN_LOG2];
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      if (clr_i) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + WIN_LOG2'(1);
         acc_d = done_o ? '0 : sum;
      end
   end

   // Accumulator and window counter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dvfs_pstate_governor.sv
// Closed-loop DVFS governor: windowed utilization average against CSR
// thresholds, one-level P-state steps sequenced through the regulator.
// Optional build macro DVFS_STATS_EN adds transition counters and the
// last evaluated average.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ACCUM    | accumulating utilization over the window
// EVAL     | one cycle: compare average against thresholds, pick target
// VUP      | raise voltage (handshake), then frequency and pstate
// FDN      | frequency already lowered, lower voltage (handshake)
// SETTLE   | hold-off before the next window starts
module dvfs_pstate_governor
   import dvfs_pkg::*;
#(
   parameter int NUM_PSTATES   = 4,
   parameter int WIN_LOG2      = 10,
   parameter int SETTLE_CYCLES = 256,
   parameter int VREG_TIMEOUT  = 1024
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [9:0]                    util_milli,
   input  logic                          util_override_en,
   input  logic [9:0]                    util_override_milli,
   input  logic [6:0]                    thresh_high_pct,
   input  logic [6:0]                    thresh_low_pct,
   dvfs_pstate_governor_if.master        vreg,
   output pstate_t                       pstate,
   output logic [15:0]                   cur_freq_mhz,
   output logic [15:0]                   cur_volt_mv,
   output logic                          pstate_change,
   output logic                          vreg_timeout_err
`ifdef DVFS_STATS_EN
   ,
   output logic [15:0]                   up_count,
   output logic [15:0]                   down_count,
   output logic [9:0]                    last_avg_milli
`endif
);
   localparam int TMAX = (VREG_TIMEOUT > SETTLE_CYCLES) ? VREG_TIMEOUT : SETTLE_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] TO_LOAD = TW'(VREG_TIMEOUT - 1);
   localparam logic [TW-1:0] ST_LOAD = TW'(SETTLE_CYCLES - 1);

   gov_state_t  state_q;
   hs_phase_t   phase_q;
   pstate_t     pstate_q, target_q;
   logic [9:0]  avg_q;
   logic [TW-1:0] timer_q;
   logic [15:0] freq_q, volt_q, vtgt_q;
   logic        req_q, chg_q, err_q;
`ifdef DVFS_STATS_EN
   logic [15:0] up_cnt_q, dn_cnt_q;
   logic [9:0]  last_avg_q;
`endif

   logic [9:0]  util_sel, win_avg;
   logic        win_done, win_en, win_clr;
   logic [10:0] th_hi_milli, th_lo_milli;
   logic        up_hit, dn_hit, can_up, can_dn;

   // Sample selection, threshold scaling and the EVAL decision terms.
   always_comb begin
      util_sel    = util_override_en ? util_override_milli : util_milli;
      win_en      = (state_q == ST_ACCUM);
      win_clr     = (state_q == ST_VUP) || (state_q == ST_FDN) || (state_q == ST_SETTLE);
      th_hi_milli = 11'(thresh_high_pct) * 11'd10;
      th_lo_milli = 11'(thresh_low_pct) * 11'd10;
      can_up      = (32'(pstate_q) < NUM_PSTATES - 1);
      can_dn      = (pstate_q != '0);
      up_hit      = ({1'b0, avg_q} > th_hi_milli);
      // An inverted threshold pair disables stepping down entirely.
      dn_hit      = ({1'b0, avg_q} < th_lo_milli) && (thresh_low_pct < thresh_high_pct);
   end

   util_window_avg #(.WIN_LOG2(WIN_LOG2)) u_win (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (win_en),
      .clr_i   (win_clr),
      .util_i  (util_sel),
      .done_o  (win_done),
      .avg_o   (win_avg)
   );

   // Governor FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_ACCUM;
         phase_q  <= PH_ISSUE;
         pstate_q <= '0;
         target_q <= '0;
         avg_q    <= '0;
         timer_q  <= '0;
         freq_q   <= 16'd200;
         volt_q   <= 16'd650;
         vtgt_q   <= 16'd650;
         req_q    <= 1'b0;
         chg_q    <= 1'b0;
         err_q    <= 1'b0;
`ifdef DVFS_STATS_EN
         up_cnt_q   <= '0;
         dn_cnt_q   <= '0;
         last_avg_q <= '0;
`endif
      end else begin
         chg_q <= 1'b0;
         unique case (state_q)
            ST_ACCUM: begin
               if (win_done) begin
                  avg_q   <= win_avg;
                  state_q <= ST_EVAL;
               end
            end
            ST_EVAL: begin
`ifdef DVFS_STATS_EN
               last_avg_q <= avg_q;
`endif
               phase_q <= PH_ISSUE;
               if (up_hit && can_up) begin
                  target_q <= pstate_t'(pstate_q + 2'd1);
                  state_q  <= ST_VUP;
               end else if (dn_hit && can_dn) begin
                  target_q <= pstate_t'(pstate_q - 2'd1);
                  freq_q   <= ps_freq_mhz(pstate_t'(pstate_q - 2'd1));
                  state_q  <= ST_FDN;
               end else begin
                  state_q <= ST_ACCUM;
               end
            end
            ST_VUP, ST_FDN: begin
               unique case (phase_q)
                  PH_ISSUE: begin
                     req_q   <= 1'b1;
                     vtgt_q  <= ps_volt_mv(target_q);
                     timer_q <= TO_LOAD;
                     phase_q <= PH_WAIT;
                  end
                  PH_WAIT: begin
                     if (vreg.vreg_ack) begin
                        req_q  <= 1'b0;
                        volt_q <= ps_volt_mv(target_q);
                        if (state_q == ST_VUP) begin
                           phase_q <= PH_FREQ;
                        end else begin
                           pstate_q <= target_q;
                           chg_q    <= 1'b1;
                           timer_q  <= ST_LOAD;
                           state_q  <= ST_SETTLE;
`ifdef DVFS_STATS_EN
                           if (dn_cnt_q != 16'hFFFF) dn_cnt_q <= dn_cnt_q + 16'd1;
`endif
                        end
                     end else if (timer_q == '0) begin
                        // Abort: pstate untouched, request target back to present voltage.
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        vtgt_q  <= volt_q;
                        timer_q <= ST_LOAD;
                        state_q <= ST_SETTLE;
                     end else begin
                        timer_q <= timer_q - TW'(1);
                     end
                  end
                  default: begin
                     freq_q   <= ps_freq_mhz(target_q);
                     pstate_q <= target_q;
                     chg_q    <= 1'b1;
                     timer_q  <= ST_LOAD;
                     state_q  <= ST_SETTLE;
`ifdef DVFS_STATS_EN
                     if (up_cnt_q != 16'hFFFF) up_cnt_q <= up_cnt_q + 16'd1;
`endif
                  end
               endcase
            end
            ST_SETTLE: begin
               if (timer_q == '0) state_q <= ST_ACCUM;
               else               timer_q <= timer_q - TW'(1);
            end
            default: state_q <= ST_ACCUM;
         endcase
      end
   end

   assign vreg.vreg_req       = req_q;
   assign vreg.vreg_target_mv = vtgt_q;
   assign pstate              = pstate_q;
   assign cur_freq_mhz        = freq_q;
   assign cur_volt_mv         = volt_q;
   assign pstate_change       = chg_q;
   assign vreg_timeout_err    = err_q;
`ifdef DVFS_STATS_EN
   assign up_count       = up_cnt_q;
   assign down_count     = dn_cnt_q;
   assign last_avg_milli = last_avg_q;
`endif

endmodule

// File: tb/tb_dvfs_pstate_governor.sv
// Directed bench for the DVFS P-state governor.
module tb_dvfs_pstate_governor;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [9:0]  util_milli, util_override_milli;
   logic        util_override_en;
   logic [6:0]  thresh_high_pct, thresh_low_pct;
   logic [1:0]  pstate;
   logic [15:0] cur_freq_mhz, cur_volt_mv;
   logic        pstate_change, vreg_timeout_err;
`ifdef DVFS_STATS_EN
   logic [15:0] up_count, down_count;
   logic [9:0]  last_avg_milli;
`endif

   dvfs_pstate_governor_if vreg ();

   dvfs_pstate_governor dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .util_milli          (util_milli),
      .util_override_en    (util_override_en),
      .util_override_milli (util_override_milli),
      .thresh_high_pct     (thresh_high_pct),
      .thresh_low_pct      (thresh_low_pct),
      .vreg                (vreg.master),
      .pstate              (pstate),
      .cur_freq_mhz        (cur_freq_mhz),
      .cur_volt_mv         (cur_volt_mv),
      .pstate_change       (pstate_change),
      .vreg_timeout_err    (vreg_timeout_err)
`ifdef DVFS_STATS_EN
      ,
      .up_count            (up_count),
      .down_count          (down_count),
      .last_avg_milli      (last_avg_milli)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_req(input int budget, output int cycles);
      cycles = 0;
      while (vreg.vreg_req !== 1'b1 && cycles < budget) begin
         step();
         cycles++;
      end
      chk("req_seen", 32'(vreg.vreg_req), 1);
   endtask

   task automatic check_state(input string tag, input int ps, input int f, input int v);
      chk({tag, "_pstate"}, 32'(pstate), ps);
      chk({tag, "_freq"}, 32'(cur_freq_mhz), f);
      chk({tag, "_volt"}, 32'(cur_volt_mv), v);
   endtask

   // Voltage-up handshake, ack 5 cycles after the request is seen.
   task automatic vup_hs(input int lat_exp, input int ps_old, input int f_old, input int f_new,
                         input int v_new);
      int lat;
      wait_req(1400, lat);
      chk("vup_latency", lat, lat_exp);
      chk("vup_target", 32'(vreg.vreg_target_mv), v_new);
      repeat (5) step();
      chk("vup_req_held", 32'(vreg.vreg_req), 1);
      vreg.vreg_ack = 1'b1;
      step();
      vreg.vreg_ack = 1'b0;
      chk("vup_req_drop", 32'(vreg.vreg_req), 0);
      check_state("vup_volt_first", ps_old, f_old, v_new);
      chk("vup_no_early_pulse", 32'(pstate_change), 0);
      step();
      check_state("vup_done", ps_old + 1, f_new, v_new);
      chk("vup_pulse", 32'(pstate_change), 1);
      step();
      chk("vup_pulse_one", 32'(pstate_change), 0);
   endtask

   // Frequency-down then voltage-down handshake.
   task automatic fdn_hs(input int ps_old, input int f_new, input int v_old, input int v_new);
      int n;
      n = 0;
      while (cur_freq_mhz == 16'(ps_old * 200 + 200) && n < 2400) begin
         step();
         n++;
      end
      check_state("fdn_freq_first", ps_old, f_new, v_old);
      chk("fdn_no_req_yet", 32'(vreg.vreg_req), 0);
      step();
      chk("fdn_req", 32'(vreg.vreg_req), 1);
      chk("fdn_target", 32'(vreg.vreg_target_mv), v_new);
      repeat (3) step();
      vreg.vreg_ack = 1'b1;
      step();
      vreg.vreg_ack = 1'b0;
      chk("fdn_req_drop", 32'(vreg.vreg_req), 0);
      check_state("fdn_done", ps_old - 1, f_new, v_new);
      chk("fdn_pulse", 32'(pstate_change), 1);
      step();
      chk("fdn_pulse_one", 32'(pstate_change), 0);
   endtask

   // Watch for any request or pstate change over a span of cycles.
   task automatic quiet(input string tag, input int cycles, input int ps);
      int seen_req, seen_chg, seen_ps;
      seen_req = 0;
      seen_chg = 0;
      seen_ps  = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (vreg.vreg_req !== 1'b0) seen_req++;
         if (pstate_change !== 1'b0) seen_chg++;
         if (pstate !== 2'(ps)) seen_ps++;
      end
      chk({tag, "_no_req"}, seen_req, 0);
      chk({tag, "_no_change"}, seen_chg, 0);
      chk({tag, "_pstate_stable"}, seen_ps, 0);
   endtask

   initial begin
      int early, lat, hi;
      reset_n             = 1'b0;
      util_milli          = 10'd0;
      util_override_en    = 1'b1;
      util_override_milli = 10'd900;
      thresh_high_pct     = 7'd80;
      thresh_low_pct      = 7'd50;
      vreg.vreg_ack       = 1'b0;
      repeat (3) step();

      check_state("reset", 0, 200, 650);
      chk("reset_req", 32'(vreg.vreg_req), 0);
      chk("reset_target", 32'(vreg.vreg_target_mv), 650);
      chk("reset_change", 32'(pstate_change), 0);
      chk("reset_err", 32'(vreg_timeout_err), 0);

      // Ramp up: the first window must complete before any request.
      reset_n = 1'b1;
      early = 0;
      for (int i = 0; i < 1024; i++) begin
         step();
         if (vreg.vreg_req !== 1'b0) early++;
      end
      chk("no_req_first_window", early, 0);
      vup_hs(2, 0, 200, 400, 700);
      vup_hs(1281, 1, 400, 600, 800);
      vup_hs(1281, 2, 600, 800, 900);
      quiet("p3_saturate", 1500, 3);
      check_state("p3_hold", 3, 800, 900);

      // Ramp down to P0.
      util_override_milli = 10'd100;
      fdn_hs(3, 600, 900, 800);
      fdn_hs(2, 400, 800, 700);
      fdn_hs(1, 200, 700, 650);
      quiet("p0_floor", 1500, 0);
      check_state("p0_hold", 0, 200, 650);

      // Hysteresis band: no action across four windows.
      util_override_milli = 10'd650;
      quiet("hysteresis", 4 * 1024 + 300, 0);

      // Timeout: request held for exactly VREG_TIMEOUT cycles.
      util_override_milli = 10'd900;
      wait_req(2400, lat);
      hi = 1;
      while (vreg.vreg_req === 1'b1 && hi < 2000) begin
         step();
         if (vreg.vreg_req === 1'b1) hi++;
      end
      chk("timeout_req_cycles", hi, 1024);
      chk("timeout_err", 32'(vreg_timeout_err), 1);
      chk("timeout_target_restored", 32'(vreg.vreg_target_mv), 650);
      check_state("timeout_state", 0, 200, 650);
      chk("timeout_no_pulse", 32'(pstate_change), 0);

      // Reset while a request is outstanding.
      wait_req(1400, lat);
      chk("retry_err_sticky", 32'(vreg_timeout_err), 1);
      reset_n = 1'b0;
      step();
      chk("rst_mid_req", 32'(vreg.vreg_req), 0);
      chk("rst_mid_err", 32'(vreg_timeout_err), 0);
      chk("rst_mid_target", 32'(vreg.vreg_target_mv), 650);
      check_state("rst_mid", 0, 200, 650);
      reset_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
